// File: rtl/dac_spi_tx_if.sv
// -----------------------------------------------------------------------------
// dac_spi_tx_if
//   Bundles the sample handshake and the DAC-side SPI pins of dac_spi_tx.
//
//   Signals:
//     sample_in    12-bit unsigned sample from the producer
//     sample_valid producer has a sample
//     ready        serializer can accept a sample (idle)
//     done         one-cycle pulse when a frame has fully completed
//     sclk         SPI clock, idle low (mode 0)
//     mosi         SPI data, MSB first
//     cs_n         DAC chip select, active low
//     ldac_n       DAC latch strobe, active low
//
//   Modports:
//     master  producer / observer side (drives sample_in, sample_valid)
//     slave   serializer side (drives everything else)
// -----------------------------------------------------------------------------
interface dac_spi_tx_if;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        ready;
  logic        done;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic        ldac_n;

  modport master (
    output sample_in, sample_valid,
    input  ready, done, sclk, mosi, cs_n, ldac_n
  );

  modport slave (
    input  sample_in, sample_valid,
    output ready, done, sclk, mosi, cs_n, ldac_n
  );
endinterface

// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
//   Serializes 12-bit samples into 16-bit SPI mode-0 frames for an MCP4921-class
//   DAC: {CMD[3:0], sample[11:0]}, MSB first, followed by an LDAC strobe.
//
//   Frame sequence (D = CLK_DIV clk cycles per step):
//     IDLE -> SETUP (D) -> SHIFT (16 bits x 2D) -> HOLD (D) -> LATCH (D) -> IDLE
//   One sample every 35*D+1 cycles when the producer keeps valid high.
//
//   Parameters:
//     CLK_DIV  SCLK half-period in clk cycles, 1..255
//     CMD      DAC config nibble sent ahead of the data
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   dac_spi_tx_if.slave (handshake + SPI pins)
// -----------------------------------------------------------------------------
module dac_spi_tx #(
  parameter int         CLK_DIV = 4,
  parameter logic [3:0] CMD     = 4'b0011
) (
  input  logic         clk,
  input  logic         rst,
  dac_spi_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LATCH
  } state_e;

  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;   // cycles spent in the current step
  logic [3:0]    bit_q,   bit_d;     // index of the bit on mosi
  logic          half_q,  half_d;    // 0: sclk low phase, 1: sclk high phase
  logic [15:0]   shift_q, shift_d;

  logic cs_n_q,   cs_n_d;
  logic sclk_q,   sclk_d;
  logic ldac_n_q, ldac_n_d;
  logic done_q,   done_d;

  logic phase_end;
  assign phase_end = (phase_q == PHASE_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the shift register is reset along with the control state so an
  // aborted frame never leaks stale bits into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      half_q   <= 1'b0;
      shift_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      ldac_n_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      half_q   <= half_d;
      shift_q  <= shift_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      ldac_n_q <= ldac_n_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    half_d  = half_q;
    shift_d = shift_q;

    unique case (state_q)
      IDLE: begin
        // ready is high only here, so valid alone marks acceptance.
        if (bus.sample_valid) begin
          shift_d = {CMD, bus.sample_in};
          state_d = SETUP;
          phase_d = '0;
          bit_d   = 4'd15;
          half_d  = 1'b0;
        end
      end

      SETUP: begin
        if (phase_end) begin
          state_d = SHIFT;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      SHIFT: begin
        if (phase_end) begin
          phase_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            half_d  = 1'b0;
            state_d = HOLD;
          end else begin
            // Advance the data only at the start of a low phase, so mosi is
            // settled for a full half-period before every rising sclk.
            half_d  = 1'b0;
            bit_d   = bit_q - 4'd1;
            shift_d = {shift_q[14:0], 1'b0};
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      HOLD: begin
        if (phase_end) begin
          state_d = LATCH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      LATCH: begin
        if (phase_end) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state so the registered pins change on
  // the same edge as the state itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    cs_n_d   = 1'b1;
    ldac_n_d = 1'b1;
    unique case (state_d)
      SETUP, SHIFT, HOLD: cs_n_d   = 1'b0;
      LATCH:              ldac_n_d = 1'b0;
      default:            ;
    endcase
    sclk_d = (state_d == SHIFT) && half_d;
    done_d = (state_q == LATCH) && (state_d == IDLE);
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.mosi   = ((state_q == SETUP) || (state_q == SHIFT)) && shift_q[15];
  assign bus.sclk   = sclk_q;
  assign bus.cs_n   = cs_n_q;
  assign bus.ldac_n = ldac_n_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_tx
//   Self-checking bench for dac_spi_tx. Two instances (CLK_DIV=4 and 1) share
//   clk/rst; 'sel' picks which one is driven and observed. A cycle-accurate
//   SPI monitor captures each frame; expected values come from the frame
//   word {4'b0011, sample} and the timing formulas of the DAC protocol.
// -----------------------------------------------------------------------------
module tb_dac_spi_tx;

  logic clk;
  logic rst;

  dac_spi_tx_if if4 ();
  dac_spi_tx_if if1 ();

  dac_spi_tx #(.CLK_DIV(4)) u_div4 (.clk(clk), .rst(rst), .bus(if4.slave));
  dac_spi_tx #(.CLK_DIV(1)) u_div1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit sel      = 1'b0;   // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance

  logic m_cs, m_sclk, m_mosi, m_ldac, m_done, m_ready;
  always_comb begin
    if (sel) begin
      m_cs = if1.cs_n; m_sclk = if1.sclk; m_mosi = if1.mosi;
      m_ldac = if1.ldac_n; m_done = if1.done; m_ready = if1.ready;
    end else begin
      m_cs = if4.cs_n; m_sclk = if4.sclk; m_mosi = if4.mosi;
      m_ldac = if4.ldac_n; m_done = if4.done; m_ready = if4.ready;
    end
  end

  typedef struct packed {
    logic [7:0]  rises;
    logic [7:0]  cs_falls;
    logic [15:0] cs_fall_cyc;
    logic [15:0] cs_low;
    logic [15:0] cs_tail;      // cs_n-high cycles after the frame, through done
    logic [15:0] first_rise;
    logic [7:0]  period_bad;
    logic [7:0]  mosi_bad;
    logic [15:0] ldac_start;
    logic [15:0] ldac_low;
    logic [15:0] done_cyc;
    logic [7:0]  ready_bad;
    logic        done_after;
    logic        cs_after;
    logic        timeout;
  } timing_t;

  typedef struct {
    logic [15:0] data;
    timing_t     t;
  } obs_t;

  function automatic int div();
    return sel ? 1 : 4;
  endfunction

  // Reference: what the DAC should see for one sample, from the protocol rules.
  function automatic obs_t model(input logic [11:0] s, input int d, input bit chain);
    obs_t e;
    e.data          = {4'b0011, s};
    e.t             = '0;
    e.t.rises       = 8'd16;
    e.t.cs_falls    = 8'd1;
    e.t.cs_fall_cyc = 16'd1;
    e.t.cs_low      = 16'(34 * d);
    e.t.cs_tail     = 16'(d + 1);
    e.t.first_rise  = 16'(1 + 2 * d);
    e.t.ldac_start  = 16'(1 + 34 * d);
    e.t.ldac_low    = 16'(d);
    e.t.done_cyc    = 16'(1 + 35 * d);
    e.t.done_after  = 1'b0;
    e.t.cs_after    = chain ? 1'b0 : 1'b1;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [11:0] s);
    if (sel) begin
      if1.sample_valid = v; if1.sample_in = s;
    end else begin
      if4.sample_valid = v; if4.sample_in = s;
    end
  endtask

  // Runs one frame and records what the SPI pins did.
  //   skip  : inputs already set so the next rising edge is the acceptance
  //   chain : keep valid high and present next_s right after acceptance
  //   rnd   : scramble sample_in/sample_valid every cycle while busy
  task automatic run_frame(input logic [11:0] s, input bit skip, input bit chain,
                           input logic [11:0] next_s, input bit rnd, output obs_t o);
    obs_t r;
    int   d = div();
    int   last_rise = 0;
    logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
    r.data = '0;
    r.t    = '0;
    if (!skip) begin
      @(negedge clk);
      for (int w = 0; w < 50 && !m_ready; w++) @(negedge clk);
      drive(1'b1, s);
    end
    @(posedge clk);
    #1;
    if (chain) drive(1'b1, next_s);
    else       drive(1'b0, s);
    for (int cyc = 1; cyc <= 35 * d + 10; cyc++) begin
      @(negedge clk);
      if (!m_cs) begin
        r.t.cs_low++;
        if (p_cs) begin
          r.t.cs_falls++;
          if (r.t.cs_fall_cyc == 0) r.t.cs_fall_cyc = 16'(cyc);
        end
      end else if (r.t.cs_falls != 0) begin
        r.t.cs_tail++;
      end
      if (m_sclk && !p_sclk) begin
        r.t.rises++;
        r.data = {r.data[14:0], m_mosi};
        if (m_mosi !== p_mosi) r.t.mosi_bad++;
        if (r.t.rises == 1) r.t.first_rise = 16'(cyc);
        else if (cyc - last_rise != 2 * d) r.t.period_bad++;
        last_rise = cyc;
      end
      if (m_sclk && p_sclk && (m_mosi !== p_mosi)) r.t.mosi_bad++;
      if (!m_ldac) begin
        r.t.ldac_low++;
        if (r.t.ldac_start == 0) r.t.ldac_start = 16'(cyc);
      end
      if (m_done !== m_ready) r.t.ready_bad++;
      if (m_done) begin
        r.t.done_cyc = 16'(cyc);
        if (!chain) drive(1'b0, 12'h000);
        break;
      end
      if (rnd) drive(1'($urandom_range(0, 1)), 12'($urandom));
      p_cs = m_cs; p_sclk = m_sclk; p_mosi = m_mosi;
    end
    if (r.t.done_cyc == 0) begin
      r.t.timeout = 1'b1;
      drive(1'b0, 12'h000);
    end else if (!chain) begin
      @(negedge clk);
      r.t.done_after = m_done;
      r.t.cs_after   = m_cs;
    end
    o = r;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({m_cs, m_sclk, m_mosi, m_ldac, m_done, m_ready} !== 6'b100101) begin
        failures++;
        $display("FAIL reset_idle[%0d]: got cs,sclk,mosi,ldac,done,ready=%b expected 100101",
                 i, {m_cs, m_sclk, m_mosi, m_ldac, m_done, m_ready});
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    obs_t o, e;
    sel = 1'b0;
    run_frame(12'hABC, 1'b0, 1'b0, 12'h000, 1'b0, o);
    e = model(12'hABC, 4, 1'b0);
    checks++;
    if (o.data !== e.data) begin
      failures++;
      $display("FAIL single_data: got %h expected %h", o.data, e.data);
    end
    checks++;
    if (o.t !== e.t) begin
      failures++;
      $display("FAIL single_timing: got %h expected %h", o.t, e.t);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2, e1, e2;
    sel = 1'b0;
    run_frame(12'h000, 1'b0, 1'b1, 12'hFFF, 1'b0, o1);
    run_frame(12'hFFF, 1'b1, 1'b0, 12'h000, 1'b0, o2);
    e1 = model(12'h000, 4, 1'b1);
    e2 = model(12'hFFF, 4, 1'b0);
    checks++;
    if (o1.data !== e1.data) begin
      failures++;
      $display("FAIL b2b_data0: got %h expected %h", o1.data, e1.data);
    end
    checks++;
    if (o1.t !== e1.t) begin
      failures++;
      $display("FAIL b2b_timing0: got %h expected %h", o1.t, e1.t);
    end
    checks++;
    if (o2.data !== e2.data) begin
      failures++;
      $display("FAIL b2b_data1: got %h expected %h", o2.data, e2.data);
    end
    // cs_n high gap = tail of frame 0 (D+1) plus an immediate fall in frame 1.
    checks++;
    if (o2.t !== e2.t) begin
      failures++;
      $display("FAIL b2b_timing1: got %h expected %h", o2.t, e2.t);
    end
  endtask

  task automatic test_busy_changes();
    obs_t o, e;
    sel = 1'b0;
    run_frame(12'h123, 1'b0, 1'b0, 12'h000, 1'b1, o);
    e = model(12'h123, 4, 1'b0);
    checks++;
    if (o.data !== e.data) begin
      failures++;
      $display("FAIL busy_data: got %h expected %h", o.data, e.data);
    end
    checks++;
    if (o.t !== e.t) begin
      failures++;
      $display("FAIL busy_timing: got %h expected %h", o.t, e.t);
    end
  endtask

  task automatic test_reset_midframe();
    obs_t o, e;
    int   rises = 0;
    logic p_sclk = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    drive(1'b1, 12'($urandom));
    @(posedge clk);
    #1;
    drive(1'b0, 12'h000);
    // Nine rising sclk edges puts us inside bit 7 (bits 15..7).
    for (int c = 0; c < 200 && rises < 9; c++) begin
      @(negedge clk);
      if (m_sclk && !p_sclk) rises++;
      p_sclk = m_sclk;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rises != 9 || {m_cs, m_sclk, m_mosi, m_ldac, m_done, m_ready} !== 6'b100101) begin
      failures++;
      $display("FAIL reset_midframe: rises=%0d got cs,sclk,mosi,ldac,done,ready=%b expected 9 and 100101",
               rises, {m_cs, m_sclk, m_mosi, m_ldac, m_done, m_ready});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_frame(12'h5A5, 1'b0, 1'b0, 12'h000, 1'b0, o);
    e = model(12'h5A5, 4, 1'b0);
    checks++;
    if (o.data !== e.data || o.t !== e.t) begin
      failures++;
      $display("FAIL after_reset_frame: got %h/%h expected %h/%h", o.data, o.t, e.data, e.t);
    end
  endtask

  task automatic test_clkdiv1();
    obs_t o, e;
    sel = 1'b1;
    run_frame(12'h801, 1'b0, 1'b0, 12'h000, 1'b0, o);
    e = model(12'h801, 1, 1'b0);
    checks++;
    if (o.data !== e.data) begin
      failures++;
      $display("FAIL div1_data: got %h expected %h", o.data, e.data);
    end
    checks++;
    if (o.t !== e.t) begin
      failures++;
      $display("FAIL div1_timing: got %h expected %h", o.t, e.t);
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    obs_t        o, e;
    logic [11:0] s;
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1));
      s   = 12'($urandom);
      run_frame(s, 1'b0, 1'b0, 12'h000, 1'b0, o);
      e = model(s, div(), 1'b0);
      checks++;
      if (o.data !== e.data) begin
        failures++;
        $display("FAIL rand_data[%0d] div=%0d: got %h expected %h", i, div(), o.data, e.data);
      end
      checks++;
      if (o.t !== e.t) begin
        failures++;
        $display("FAIL rand_timing[%0d] div=%0d: got %h expected %h", i, div(), o.t, e.t);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if4.sample_valid = 1'b0; if4.sample_in = 12'h000;
    if1.sample_valid = 1'b0; if1.sample_in = 12'h000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_changes();
    test_reset_midframe();
    test_clkdiv1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
